approx_mult_err_monitor: RTL

- Self-checking characterisation stage for the 8x8 approximate multipliers in this tree.
- Upstream role: it sweeps all 65536 operand pairs (A,B) into the multiplier under test.
- Downstream role: it takes the multiplier's approximate product back and compares it against the exact A*B.
- It accumulates error count, maximum error distance (ED) and summed ED for on-chip error characterisation of each LUT-mapped configuration.

---
 rtl/approx_mult_err_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/approx_mult_err_monitor.sv
// rtl/approx_mult_err_monitor.sv - exhaustive 8x8 operand sweep with error-distance metrics
// Drives every (A,B) pair into a multiplier under test and scores its product against A*B.
module approx_mult_err_monitor #(
    parameter int LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic        op_valid,
    input  logic [15:0] prod_in,
    output logic        busy,
    output logic        done,
    output logic [16:0] err_cnt,
    output logic [15:0] ed_max,
    output logic [31:0] ed_sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pair_cnt;
    logic [2:0]  drain_cnt;
    logic        launch;
    logic        last_pair;
    logic        drain_last;

    logic [16:0] aligned;
    logic        aligned_valid;
    logic [7:0]  aligned_a;
    logic [7:0]  aligned_b;
    logic [15:0] exact;
    logic [16:0] diff;
    logic [16:0] diff_neg;
    logic [15:0] ed;

    assign launch     = start && ((state == IDLE) || (state == DONE));
    assign last_pair  = (state == SWEEP) && (pair_cnt == 16'hFFFF);
    // DRAIN lasts exactly LAT cycles so the final aligned pair lands in its last cycle
    assign drain_last = (state == DRAIN) && (drain_cnt == 3'(LAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                if (last_pair) begin
                    state_nxt = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (launch) begin
                pair_cnt <= '0;
            end else if (state == SWEEP) begin
                pair_cnt <= pair_cnt + 16'd1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    assign op_valid = (state == SWEEP);
    assign op_a     = op_valid ? pair_cnt[15:8] : 8'd0;
    assign op_b     = op_valid ? pair_cnt[7:0]  : 8'd0;
    assign busy     = (state == SWEEP) || (state == DRAIN);
    assign done     = (state == DONE);

    // Delay line lines up each issued pair with the product it produces LAT cycles later
    generate
        if (LAT == 0) begin : g_comb
            assign aligned = {op_valid, op_a, op_b};
        end else begin : g_dly
            logic [16:0] dly [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= {op_valid, op_a, op_b};
                    for (int i = 1; i < LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign aligned = dly[LAT-1];
        end
    endgenerate

    assign aligned_valid = aligned[16];
    assign aligned_a     = aligned[15:8];
    assign aligned_b     = aligned[7:0];

    assign exact    = {8'd0, aligned_a} * {8'd0, aligned_b};
    assign diff     = {1'b0, prod_in} - {1'b0, exact};
    assign diff_neg = -diff;
    assign ed       = diff[16] ? diff_neg[15:0] : diff[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            ed_max  <= '0;
            ed_sum  <= '0;
        end else if (launch) begin
            err_cnt <= '0;
            ed_max  <= '0;
            ed_sum  <= '0;
        end else if (aligned_valid) begin
            err_cnt <= err_cnt + 17'(ed != 16'd0);
            ed_sum  <= ed_sum + 32'(ed);
            if (ed > ed_max) begin
                ed_max <= ed;
            end
        end
    end

endmodule
